sdp_ram: RTL and testbench

//   Simple dual-port synchronous RAM: port A write-only, port B read-only, one clock.

---
 rtl/sdp_ram.sv | 53 +++++
 tb/tb_sdp_ram.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, byte-strobed write port A, read-first read port B
module sdp_ram #(
    parameter  int DATA_WIDTH = 32,
    parameter  int MEM_DEPTH  = 1024,
    parameter  int OUT_REG    = 0,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STRB_WIDTH-1:0] wena,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  renb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb
);
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  wr_ok, rd_ok;
    logic [DATA_WIDTH-1:0] rd_d, rd_q;

    always_comb begin
        wr_ok = {1'b0, addra} < (ADDR_WIDTH+1)'(MEM_DEPTH);
        rd_ok = {1'b0, addrb} < (ADDR_WIDTH+1)'(MEM_DEPTH);
        rd_d  = renb ? (rd_ok ? mem[addrb] : '0) : rd_q;
    end

    // Array is never reset; rst only gates writes so a write during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst && wr_ok)
            for (int i = 0; i < STRB_WIDTH; i++)
                if (wena[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_q <= '0;
        else      rd_q <= rd_d;
    end

    generate
        if (OUT_REG != 0) begin : g_out
            logic [DATA_WIDTH-1:0] out_d, out_q;
            always_comb out_d = rd_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) out_q <= '0;
                else      out_q <= out_d;
            end
            assign doutb = out_q;
        end else begin : g_dir
            assign doutb = rd_q;
        end
    endgenerate
endmodule

// File: tb/tb_sdp_ram.sv
// tb_sdp_ram: directed vector table plus reset and random scoreboard sequences for sdp_ram
module tb_sdp_ram;
    typedef struct {
        logic [3:0]  wena;
        logic [9:0]  addra;
        logic [31:0] dina;
        logic        renb;
        logic [9:0]  addrb;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  wena = '0;
    logic [9:0]  addra = '0;
    logic [31:0] dina = '0;
    logic        renb = 1'b0;
    logic [9:0]  addrb = '0;
    logic [31:0] doutb;

    int errors = 0;
    int checks = 0;

    sdp_ram dut (
        .clk(clk), .rst(rst), .wena(wena), .addra(addra), .dina(dina),
        .renb(renb), .addrb(addrb), .doutb(doutb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: doutb=%h expected=%h", name, act, req);
        end
    endtask

    task automatic drive(input logic [3:0] we, input logic [9:0] aa, input logic [31:0] di,
                         input logic re, input logic [9:0] ab);
        wena = we; addra = aa; dina = di; renb = re; addrb = ab;
    endtask

    vec_t        vecs [16];
    logic [31:0] model [16];
    logic [31:0] exp;

    initial begin
        vecs[0]  = '{4'hF, 10'd5,    32'hDEADBEEF, 1'b0, 10'd0,    32'h00000000};
        vecs[1]  = '{4'h0, 10'd0,    32'h0,        1'b1, 10'd5,    32'hDEADBEEF};
        vecs[2]  = '{4'hF, 10'd7,    32'h11223344, 1'b0, 10'd0,    32'hDEADBEEF};
        vecs[3]  = '{4'h2, 10'd7,    32'hAABBCCDD, 1'b0, 10'd0,    32'hDEADBEEF};
        vecs[4]  = '{4'h0, 10'd0,    32'h0,        1'b1, 10'd7,    32'h1122CC44};
        vecs[5]  = '{4'hF, 10'd9,    32'h00000001, 1'b0, 10'd0,    32'h1122CC44};
        vecs[6]  = '{4'hF, 10'd9,    32'h00000002, 1'b1, 10'd9,    32'h00000001};
        vecs[7]  = '{4'h0, 10'd0,    32'h0,        1'b1, 10'd9,    32'h00000002};
        vecs[8]  = '{4'h0, 10'd0,    32'h0,        1'b1, 10'd5,    32'hDEADBEEF};
        vecs[9]  = '{4'h0, 10'd0,    32'h0,        1'b0, 10'd9,    32'hDEADBEEF};
        vecs[10] = '{4'hF, 10'd0,    32'hA5A5A5A5, 1'b0, 10'd0,    32'hDEADBEEF};
        vecs[11] = '{4'hF, 10'd1023, 32'h5A5A5A5A, 1'b1, 10'd0,    32'hA5A5A5A5};
        vecs[12] = '{4'h0, 10'd0,    32'h0,        1'b1, 10'd1023, 32'h5A5A5A5A};
        vecs[13] = '{4'h0, 10'd0,    32'h0,        1'b1, 10'd0,    32'hA5A5A5A5};
        vecs[14] = '{4'h0, 10'd0,    32'hFFFFFFFF, 1'b1, 10'd0,    32'hA5A5A5A5};
        vecs[15] = '{4'h0, 10'd0,    32'h0,        1'b1, 10'd0,    32'hA5A5A5A5};

        #2 rst = 1'b0;
        #1 check("reset_async", doutb, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        check("reset_held", doutb, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].wena, vecs[i].addra, vecs[i].dina, vecs[i].renb, vecs[i].addrb);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), doutb, vecs[i].exp);
        end

        // Fill a small window so the random phase never reads unwritten words.
        for (int a = 0; a < 16; a++) begin
            model[a] = $urandom;
            drive(4'hF, 10'(a), model[a], 1'b0, 10'd0);
            @(posedge clk); #1;
        end
        exp = 32'hA5A5A5A5;
        check("fill_hold", doutb, exp);

        for (int i = 0; i < 100; i++) begin
            logic [3:0]  we;
            logic [3:0]  aa, ab;
            logic [31:0] di;
            logic        re;
            we = 4'($urandom); aa = 4'($urandom); ab = 4'($urandom);
            di = $urandom; re = 1'($urandom);
            if (i == 50) begin we = 4'hF; aa = ab; re = 1'b1; end
            drive(we, 10'(aa), di, re, 10'(ab));
            if (i == 50) begin
                rst = 1'b0;
                #1 check("rand_rst_async", doutb, 32'h0);
            end
            @(posedge clk); #1;
            if (i == 50) begin
                rst = 1'b1;
                exp = 32'h0;
            end else begin
                if (re) exp = model[ab];
                for (int b = 0; b < 4; b++)
                    if (we[b]) model[aa][8*b +: 8] = di[8*b +: 8];
            end
            check($sformatf("rand%0d", i), doutb, exp);
        end

        drive(4'h0, 10'd0, 32'h0, 1'b0, 10'd0);
        for (int a = 0; a < 16; a++) begin
            drive(4'h0, 10'd0, 32'h0, 1'b1, 10'(a));
            @(posedge clk); #1;
            check($sformatf("final%0d", a), doutb, model[a]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
